// File: rtl/fpga_out_dis_pkg.sv
// Shared types for the sequenced FPGA output disable: FSM state encoding and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshakes in this block).
package fpga_out_dis_pkg;

   localparam logic [2:0] ST_ON_ENC      = 3'd0;
   localparam logic [2:0] ST_SHUT_ENC    = 3'd1;
   localparam logic [2:0] ST_OFF_ENC     = 3'd2;
   localparam logic [2:0] ST_HOLD_ENC    = 3'd3;
   localparam logic [2:0] ST_RESTORE_ENC = 3'd4;

   typedef enum logic [2:0] {
      ST_ON      = ST_ON_ENC,
      ST_SHUT    = ST_SHUT_ENC,
      ST_OFF     = ST_OFF_ENC,
      ST_HOLD    = ST_HOLD_ENC,
      ST_RESTORE = ST_RESTORE_ENC
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/oe_seq_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded count.
// Latency: a load of N at edge e makes done high during the cycle before edge e+N.
// Backpressure: none; load always wins over counting, count stops at zero.
//
// Ports: clk, reset (sync, active-high), load/load_val (restart count), done (count == 1).
module oe_seq_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flagging the final count lets the owner act on exactly the expiry edge.
   assign done = (cnt_q == W'(1));

endmodule

// File: rtl/fpga_out_dis_seq.sv
// Sequenced multi-channel FPGA output disable: staggered shutdown, hold, reverse-order restore.
// Latency: som_input -> fpga_output 1 clk; channel 0 drops on the edge that samples dis_input.
// Backpressure: none; dis_input is a level request, sequences are never stalled.
//
// Ports: clk, reset (sync, active-high), som_input[CH_NUM] (SoM drive), dis_input (disable
// request), clear (releases latched disable), fpga_output[CH_NUM] (gated, registered),
// all_off (mask empty), busy (SHUT/HOLD/RESTORE), dis_latched (pending latched disable).
module fpga_out_dis_seq
   import fpga_out_dis_pkg::*;
#(
   parameter int CH_NUM      = 4,
   parameter int GAP_CYCLES  = 16,
   parameter int HOLD_CYCLES = 1000,
   parameter int LATCH_MODE  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CH_NUM-1:0] som_input,
   input  logic              dis_input,
   input  logic              clear,
   output logic [CH_NUM-1:0] fpga_output,
   output logic              all_off,
   output logic              busy,
   output logic              dis_latched
);

   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int TMR_W  = max_int(GAP_W, HOLD_W);
   localparam int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CH_NUM - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES);
   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES);

   state_t              state_q, state_d;
   logic [CH_NUM-1:0]   en_q, en_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CH_NUM-1:0]   fpga_output_q;
   logic                all_off_q;
   logic                busy_q, busy_d;
   logic                dis_latched_q, dis_latched_d;

   logic                tmr_load;
   logic [TMR_W-1:0]    tmr_val;
   logic                tmr_done;

   // One timer serves both gap and hold: the two intervals never overlap.
   oe_seq_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      en_d     = en_q;
      idx_d    = idx_q;
      tmr_load = 1'b0;
      tmr_val  = '0;

      // A new request in the same cycle as clear keeps the latch set.
      if (LATCH_MODE != 0) begin
         dis_latched_d = dis_input | (dis_latched_q & ~clear);
      end else begin
         dis_latched_d = 1'b0;
      end

      case (state_q)
         ST_ON: begin
            if (dis_input) begin
               en_d[0] = 1'b0;
               if (CH_NUM == 1) begin
                  state_d = ST_OFF;
               end else begin
                  state_d  = ST_SHUT;
                  idx_d    = IDX_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = GAP_LOAD;
               end
            end
         end

         ST_SHUT: begin
            if (tmr_done) begin
               en_d[idx_q] = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_OFF;
               end else begin
                  idx_d    = idx_q + IDX_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = GAP_LOAD;
               end
            end
         end

         ST_OFF: begin
            if (!dis_input && !dis_latched_q) begin
               state_d  = ST_HOLD;
               tmr_load = 1'b1;
               tmr_val  = HOLD_LOAD;
            end
         end

         ST_HOLD: begin
            if (dis_input) begin
               // Back to OFF with the hold count discarded; it restarts on release.
               state_d  = ST_OFF;
               tmr_load = 1'b1;
               tmr_val  = '0;
            end else if (tmr_done) begin
               en_d[LAST_IDX] = 1'b1;
               if (CH_NUM == 1) begin
                  state_d = ST_ON;
               end else begin
                  state_d  = ST_RESTORE;
                  idx_d    = LAST_IDX - IDX_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = GAP_LOAD;
               end
            end
         end

         ST_RESTORE: begin
            if (dis_input) begin
               // Re-enter shutdown from index 1; channels not yet restored stay off.
               en_d[0]  = 1'b0;
               state_d  = ST_SHUT;
               idx_d    = IDX_W'(1);
               tmr_load = 1'b1;
               tmr_val  = GAP_LOAD;
            end else if (tmr_done) begin
               en_d[idx_q] = 1'b1;
               if (idx_q == '0) begin
                  state_d = ST_ON;
               end else begin
                  idx_d    = idx_q - IDX_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = GAP_LOAD;
               end
            end
         end

         default: begin
            state_d = ST_ON;
            en_d    = '1;
            idx_d   = '0;
         end
      endcase

      busy_d = (state_d == ST_SHUT) || (state_d == ST_HOLD) || (state_d == ST_RESTORE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_ON;
         en_q          <= '1;
         idx_q         <= '0;
         fpga_output_q <= '0;
         all_off_q     <= 1'b0;
         busy_q        <= 1'b0;
         dis_latched_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         en_q          <= en_d;
         idx_q         <= idx_d;
         fpga_output_q <= som_input & en_d;
         all_off_q     <= ~|en_d;
         busy_q        <= busy_d;
         dis_latched_q <= dis_latched_d;
      end
   end

   assign fpga_output = fpga_output_q;
   assign all_off     = all_off_q;
   assign busy        = busy_q;
   assign dis_latched = dis_latched_q;

endmodule

// File: tb/tb_fpga_out_dis_seq.sv
module tb_fpga_out_dis_seq;

   localparam int N    = 4;
   localparam int GAP  = 3;
   localparam int HOLD = 5;

   localparam int P_ON   = 0;
   localparam int P_SHUT = 1;
   localparam int P_OFF  = 2;
   localparam int P_HOLD = 3;
   localparam int P_RST  = 4;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic         dis_input = 1'b0;
   logic         clear     = 1'b0;
   logic [N-1:0] som_input = '1;

   logic [N-1:0] out0, out1;
   logic         all0, all1, busy0, busy1, lat0, lat1;

   int total  = 0;
   int bad    = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // Model: phase per instance plus the anchor edges of the running sequence.
   int           ph [2];
   int           t0 [2];
   int           r0 [2];
   int           t1 [2];
   logic [N-1:0] m0   [2];
   logic [N-1:0] mask [2];
   logic         m_lat  [2];
   logic [N-1:0] e_out  [2];
   logic         e_all  [2];
   logic         e_busy [2];
   logic         e_lat  [2];

   always #5 clk = ~clk;

   fpga_out_dis_seq #(
      .CH_NUM(N), .GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD), .LATCH_MODE(0)
   ) u_dut0 (
      .clk(clk), .reset(reset), .som_input(som_input), .dis_input(dis_input),
      .clear(clear), .fpga_output(out0), .all_off(all0), .busy(busy0), .dis_latched(lat0)
   );

   fpga_out_dis_seq #(
      .CH_NUM(N), .GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD), .LATCH_MODE(1)
   ) u_dut1 (
      .clk(clk), .reset(reset), .som_input(som_input), .dis_input(dis_input),
      .clear(clear), .fpga_output(out1), .all_off(all1), .busy(busy1), .dis_latched(lat1)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   // Mask derived from anchor edges: channel k drops at t0 + k*GAP, returns at
   // t1 + (N-1-k)*GAP, with t1 = hold start + HOLD.
   task automatic model_step(input int i);
      logic         lat_prev;
      logic [N-1:0] nm;
      if (reset) begin
         ph[i]     = P_ON;
         mask[i]   = '1;
         m_lat[i]  = 1'b0;
         e_out[i]  = '0;
         e_all[i]  = 1'b0;
         e_busy[i] = 1'b0;
         e_lat[i]  = 1'b0;
      end else begin
         lat_prev = m_lat[i];
         m_lat[i] = (i == 1) ? (dis_input || (m_lat[i] && !clear)) : 1'b0;
         case (ph[i])
            P_ON, P_RST: if (dis_input) begin
               ph[i] = P_SHUT; t0[i] = cyc; m0[i] = mask[i];
            end
            P_OFF: if (!dis_input && !lat_prev) begin
               ph[i] = P_HOLD; r0[i] = cyc;
            end
            P_HOLD: if (dis_input) begin
               ph[i] = P_OFF;
            end else if (cyc >= r0[i] + HOLD) begin
               ph[i] = P_RST; t1[i] = r0[i] + HOLD;
            end
            default: ;
         endcase
         case (ph[i])
            P_SHUT: begin
               nm = m0[i];
               for (int k = 0; k < N; k++) if (cyc >= t0[i] + k * GAP) nm[k] = 1'b0;
               mask[i] = nm;
               if (cyc >= t0[i] + (N - 1) * GAP) ph[i] = P_OFF;
            end
            P_OFF, P_HOLD: mask[i] = '0;
            P_RST: begin
               for (int k = 0; k < N; k++) nm[k] = (cyc >= t1[i] + (N - 1 - k) * GAP);
               mask[i] = nm;
               if (&nm) ph[i] = P_ON;
            end
            default: mask[i] = '1;
         endcase
         e_out[i]  = som_input & mask[i];
         e_all[i]  = (mask[i] == '0);
         e_busy[i] = (ph[i] == P_SHUT) || (ph[i] == P_HOLD) || (ph[i] == P_RST);
         e_lat[i]  = m_lat[i];
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step(0);
      model_step(1);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mdl_out0",  32'(out0),  32'(e_out[0]));
         chk("mdl_all0",  32'(all0),  32'(e_all[0]));
         chk("mdl_busy0", 32'(busy0), 32'(e_busy[0]));
         chk("mdl_lat0",  32'(lat0),  32'(e_lat[0]));
         chk("mdl_out1",  32'(out1),  32'(e_out[1]));
         chk("mdl_all1",  32'(all1),  32'(e_all[1]));
         chk("mdl_busy1", 32'(busy1), 32'(e_busy[1]));
         chk("mdl_lat1",  32'(lat1),  32'(e_lat[1]));
      end
   end

   task automatic wait_to(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic pulse_dis(output int t);
      dis_input = 1'b1;
      @(negedge clk);
      t = cyc;
      dis_input = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int t, s, c;

      // Reset held for three edges.
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_out",  32'(out0),  32'h0);
      chk("rst_all",  32'(all0),  32'h0);
      chk("rst_busy", 32'(busy0), 32'h0);
      chk("rst_lat",  32'(lat1),  32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_out",  32'(out0),  32'hF);
      chk("post_rst_busy", 32'(busy0), 32'h0);

      // Mirroring with one cycle of latency.
      for (int k = 0; k < 6; k++) begin
         som_input = k[0] ? 4'hA : 4'h5;
         @(negedge clk);
         chk("som_follow", 32'(out0), 32'(som_input));
      end
      som_input = 4'hF;
      @(negedge clk);

      // Single-cycle request; OFF takes the cycle after the last drop, so hold
      // starts at t+10 and channel 3 returns at t+15.
      pulse_dis(t);
      chk("shut_t0",   32'(out0),  32'hE);
      chk("shut_busy", 32'(busy0), 32'h1);
      wait_to(t + 3);  chk("shut_t3", 32'(out0), 32'hC);
      wait_to(t + 6);  chk("shut_t6", 32'(out0), 32'h8);
      wait_to(t + 9);  chk("shut_t9", 32'(out0), 32'h0);
      chk("shut_all",     32'(all0),  32'h1);
      chk("off_not_busy", 32'(busy0), 32'h0);
      wait_to(t + 14); chk("hold_t14", 32'(out0), 32'h0);
      wait_to(t + 15); chk("rst_t15",  32'(out0), 32'h8);
      chk("rst_all_drop", 32'(all0), 32'h0);
      wait_to(t + 18); chk("rst_t18", 32'(out0), 32'hC);
      wait_to(t + 21); chk("rst_t21", 32'(out0), 32'hE);
      wait_to(t + 24); chk("rst_t24", 32'(out0), 32'hF);
      chk("on_not_busy", 32'(busy0), 32'h0);
      chk("latch_stuck", 32'(out1),  32'h0);
      chk("latch_set",   32'(lat1),  32'h1);
      do_reset();

      // Re-request on hold cycle 3 (edge t+13): hold restarts from t+14.
      pulse_dis(t);
      wait_to(t + 12);
      dis_input = 1'b1;
      @(negedge clk);
      dis_input = 1'b0;
      chk("rehold_off",  32'(busy0), 32'h0);
      wait_to(t + 18); chk("rehold_t18", 32'(out0), 32'h0);
      wait_to(t + 19); chk("rehold_t19", 32'(out0), 32'h8);
      wait_to(t + 22); chk("rehold_t22", 32'(out0), 32'hC);

      // Request during restore at 4'hC: ch0 already off, ch2 then ch3 drop.
      pulse_dis(s);
      chk("abort_s0", 32'(out0), 32'hC);
      wait_to(s + 3);  chk("abort_s3", 32'(out0), 32'hC);
      wait_to(s + 6);  chk("abort_s6", 32'(out0), 32'h8);
      wait_to(s + 9);  chk("abort_s9", 32'(out0), 32'h0);
      chk("abort_all", 32'(all0), 32'h1);
      wait_to(s + 24); chk("abort_back_on", 32'(out0), 32'hF);
      do_reset();

      // Latching instance: clear with request is ignored, clear alone releases.
      pulse_dis(t);
      chk("lat_set1", 32'(lat1), 32'h1);
      chk("lat_never0", 32'(lat0), 32'h0);
      wait_to(t + 15);
      chk("lat_off_out",  32'(out1),  32'h0);
      chk("lat_off_busy", 32'(busy1), 32'h0);
      dis_input = 1'b1;
      clear     = 1'b1;
      @(negedge clk);
      dis_input = 1'b0;
      clear     = 1'b0;
      chk("lat_clr_dis", 32'(lat1), 32'h1);
      wait_to(t + 20);
      chk("lat_still_off", 32'(out1), 32'h0);
      clear = 1'b1;
      @(negedge clk);
      c = cyc;
      clear = 1'b0;
      chk("lat_cleared",  32'(lat1),  32'h0);
      chk("lat_c_off",    32'(busy1), 32'h0);
      @(negedge clk);
      chk("lat_hold",     32'(busy1), 32'h1);
      wait_to(c + 5);  chk("lat_c5",  32'(out1), 32'h0);
      wait_to(c + 6);  chk("lat_c6",  32'(out1), 32'h8);
      wait_to(c + 15); chk("lat_c15", 32'(out1), 32'hF);

      repeat (30) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
